// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding load/store with WAIT_STATES cycles of latency.
// Optional even-parity protection is enabled with the DM_PARITY_EN macro.
module dm_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 200,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DM_PARITY_EN
  input  logic              req_bad_par,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef DM_PARITY_EN
  logic              par_mem [DEPTH];
`endif

  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_in_range;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  assign accept = rst_n && req_valid && req_ready;

  // In IDLE the response comes straight from the request (zero wait states), otherwise from the latch
  always_comb begin
    sel_we       = (state == S_IDLE) ? req_we : lat_we;
    sel_addr     = (state == S_IDLE) ? req_addr : lat_addr;
    sel_in_range = int'(sel_addr) < DEPTH;
    rd_data      = '0;
    rd_err       = 1'b0;
    if (!sel_in_range) begin
      rd_err = 1'b1;
    end else if (!sel_we) begin
      rd_data = mem[sel_addr];
`ifdef DM_PARITY_EN
      rd_err  = par_mem[sel_addr] != (^mem[sel_addr]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && (int'(req_addr) < DEPTH)) begin
      mem[req_addr] <= req_wdata;
`ifdef DM_PARITY_EN
      par_mem[req_addr] <= (^req_wdata) ^ req_bad_par;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            cnt       <= 3'(WAIT_STATES);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_STATES == 0) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_data;
              rsp_err   <= rd_err;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_data;
            rsp_err   <= rd_err;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed cases plus randomized traffic against a memory model.
// A second instance with zero wait states covers the back-to-back timing.
module tb_dm_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 200;
  localparam int WS     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;

  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_bad_par = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  logic              z_req_valid = 1'b0;
  logic              z_req_ready;
  logic              z_req_we = 1'b0;
  logic [ADDR_W-1:0] z_req_addr = '0;
  logic [DATA_W-1:0] z_req_wdata = '0;
  logic              z_req_bad_par = 1'b0;
  logic              z_rsp_valid;
  logic              z_rsp_ready = 1'b1;
  logic [DATA_W-1:0] z_rsp_rdata;
  logic              z_rsp_err;
  logic              z_busy;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  bit                model_written [DEPTH];
  bit                model_par_ok [DEPTH];

  dm_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DM_PARITY_EN
    .req_bad_par(req_bad_par),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  dm_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
`ifdef DM_PARITY_EN
    .req_bad_par(z_req_bad_par),
`endif
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    else
      passes++;
  endtask

  // Full request/response through the WS=2 instance, holding rsp_ready low for 'hold' cycles
  task automatic applyStimulus(input bit we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input bit bad_par, input int hold);
    logic [DATA_W-1:0] exp_data;
    bit                exp_err;
    bit                in_range;
    int                cycles;
    in_range = int'(addr) < DEPTH;
    exp_data = '0;
    exp_err  = !in_range;
    if (!we && in_range) begin
      exp_data = model_mem[addr];
      exp_err  = !model_par_ok[addr];
    end
    if (we && in_range) begin
      model_mem[addr]     = wdata;
      model_written[addr] = 1'b1;
`ifdef DM_PARITY_EN
      model_par_ok[addr]  = !bad_par;
`else
      model_par_ok[addr]  = 1'b1;
`endif
    end

    @(negedge clk);
    checkOutput("req_ready idle", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_we      = we;
    req_addr    = addr;
    req_wdata   = wdata;
    req_bad_par = bad_par;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        checkOutput("busy after accept", 32'(busy), 32'd1);
        checkOutput("req_ready after accept", 32'(req_ready), 32'd0);
      end
    end while (!rsp_valid && cycles < 20);
    checkOutput("latency", 32'(cycles), 32'(WS + 1));
    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
    checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));

    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 8'h00;
      req_wdata = 16'hDEAD;
      @(negedge clk);
      checkOutput("hold rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
      checkOutput("hold rsp_err", 32'(rsp_err), 32'(exp_err));
      checkOutput("hold req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid dropped", 32'(rsp_valid), 32'd0);
    checkOutput("busy back to idle", 32'(busy), 32'd0);
  endtask

  // Zero-wait instance: drive at a negedge, wait for ready, report the accept cycle
  task automatic z_txn(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                       input logic [DATA_W-1:0] exp_data, output int acc);
    int n;
    z_req_valid = 1'b1;
    z_req_we    = we;
    z_req_addr  = addr;
    z_req_wdata = wdata;
    n = 0;
    while (!z_req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("z ready", 32'(z_req_ready), 32'd1);
    acc = cyc + 1;
    @(negedge clk);
    checkOutput("z rsp_valid 1 cycle", 32'(z_rsp_valid), 32'd1);
    checkOutput("z rsp_rdata", 32'(z_rsp_rdata), 32'(exp_data));
    checkOutput("z rsp_err", 32'(z_rsp_err), 32'd0);
  endtask

  initial begin
    int a1, a2, hits;
    logic [DATA_W-1:0] d1, d2;
    bit we;
    logic [ADDR_W-1:0] addr;

    for (int i = 0; i < DEPTH; i++) begin
      model_written[i] = 1'b0;
      model_par_ok[i]  = 1'b1;
      model_mem[i]     = '0;
    end

    #12;
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 8'h10, 16'hA5C3, 1'b0, 0);
    applyStimulus(1'b0, 8'h10, 16'h0000, 1'b0, 0);
    applyStimulus(1'b1, 8'h00, 16'h5A5A, 1'b0, 0);
    applyStimulus(1'b1, 8'hD0, 16'h1234, 1'b0, 0);
    applyStimulus(1'b0, 8'hD0, 16'h0000, 1'b0, 0);
    applyStimulus(1'b0, 8'h00, 16'h0000, 1'b0, 0);
    applyStimulus(1'b0, 8'hC7, 16'h0000, 1'b0, 0);
    applyStimulus(1'b1, 8'hC7, 16'h7E7E, 1'b0, 0);
    applyStimulus(1'b0, 8'h10, 16'h0000, 1'b0, 5);
    applyStimulus(1'b0, 8'h00, 16'h0000, 1'b0, 0);

    // Reset while WAIT: outputs clear asynchronously, the accepted write remains committed
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h20;
    req_wdata = 16'hBEEF;
    @(posedge clk);
    #2 req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst req_ready", 32'(req_ready), 32'd1);
    checkOutput("async rst rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("async rst busy", 32'(busy), 32'd0);
    checkOutput("async rst rsp_rdata", 32'(rsp_rdata), 32'd0);
    model_mem[8'h20] = 16'hBEEF;
    model_written[8'h20] = 1'b1;
    model_par_ok[8'h20] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h20, 16'h0000, 1'b0, 1);

`ifdef DM_PARITY_EN
    applyStimulus(1'b1, 8'h05, 16'h00FF, 1'b1, 0);
    applyStimulus(1'b0, 8'h05, 16'h0000, 1'b0, 0);
    applyStimulus(1'b1, 8'h05, 16'h00FF, 1'b0, 0);
    applyStimulus(1'b0, 8'h05, 16'h0000, 1'b0, 0);
`endif

    hits = 0;
    for (int i = 0; i < 50; i++) begin
      we = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0)
        addr = 8'($urandom_range(DEPTH, 255));
      else
        addr = 8'($urandom_range(0, 15));
      if (!we && int'(addr) < DEPTH && !model_written[addr]) we = 1'b1;
      if (!we && int'(addr) < DEPTH) hits++;
      applyStimulus(we, addr, 16'($urandom), 1'b0, $urandom_range(0, 2));
    end
    checkOutput("random reads happened", 32'(hits > 0), 32'd1);

    // Zero wait states: writes, then back-to-back reads with rsp_ready held high
    d1 = 16'($urandom);
    d2 = 16'($urandom);
    @(negedge clk);
    z_txn(1'b1, 8'h01, d1, 16'h0000, a1);
    z_txn(1'b1, 8'h02, d2, 16'h0000, a2);
    z_txn(1'b0, 8'h01, 16'h0000, d1, a1);
    z_txn(1'b0, 8'h02, 16'h0000, d2, a2);
    z_req_valid = 1'b0;
    checkOutput("z accept spacing", 32'(a2 - a1), 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
